wave_pwm_dac: RTL and testbench

Downstream stage of the waveform generators (sine, square, sineSquare). It consumes 8-bit unsigned samples through a valid/ready handshake and converts each sample into one PWM period on a single output pin for an RC-filtered board DAC. A one-entry holding buffer decouples the generator from the PWM frame timing. Underrun status is reported to the top level.

---
 rtl/wave_pwm_dac.sv | 112 +++++++++++
 tb/tb_wave_pwm_dac.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_pwm_dac.sv
// Converts each WIDTH-bit sample into one 2^WIDTH-tick PWM period for an RC-filtered DAC pin.
// Latency: an accepted sample drives pwm_out from the period after the next frame boundary; pwm_out lags cnt by 1 clk.
// Backpressure: one-entry buffer, sample_ready = ~pend_full; WAVE_PWM_SIGNED_IN_EN selects two's-complement input.
module wave_pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             frame_tick,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};

  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             pwm_out_q, pwm_out_d;
  logic             frame_tick_q, frame_tick_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       underrun_cnt_q, underrun_cnt_d;

  logic             tick;
  logic             boundary;
  logic             accept;
  logic [WIDTH-1:0] sample_conv;

  // Signed input is stored as offset binary so the PWM compare stays unsigned
`ifdef WAVE_PWM_SIGNED_IN_EN
  assign sample_conv = {~sample_in[WIDTH-1], sample_in[WIDTH-2:0]};
`else
  assign sample_conv = sample_in;
`endif

  assign tick         = (pre_cnt_q == PRE_LAST);
  assign boundary     = tick && (cnt_q == CNT_LAST);
  assign sample_ready = ~pend_full_q;
  assign accept       = sample_valid && ~pend_full_q;

  // Next-state: prescaler, period counter, holding buffer, duty reload and underrun accounting
  always_comb begin
    pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
    cnt_d          = tick ? cnt_q + 1'b1 : cnt_q;
    duty_d         = duty_q;
    pend_d         = pend_q;
    pend_full_d    = pend_full_q;
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    pwm_out_d      = (cnt_q < duty_q);
    frame_tick_d   = boundary;

    // Accept can only happen while the buffer is empty, so it never collides with a reload
    if (accept) begin
      pend_d      = sample_conv;
      pend_full_d = 1'b1;
    end

    // duty changes only at the period boundary so no partial pulse is ever emitted
    if (boundary) begin
      if (pend_full_q) begin
        duty_d      = pend_q;
        pend_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
        if (underrun_cnt_q != 8'hFF) begin
          underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      duty_q         <= '0;
      pend_q         <= '0;
      pend_full_q    <= 1'b0;
      pwm_out_q      <= 1'b0;
      frame_tick_q   <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pend_q         <= pend_d;
      pend_full_q    <= pend_full_d;
      pwm_out_q      <= pwm_out_d;
      frame_tick_q   <= frame_tick_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign frame_tick   = frame_tick_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Bench for wave_pwm_dac: PRESCALE=1 instance with per-period scoreboard, plus a PRESCALE=4 instance.
// Expected duty per period is queued at accept time and compared against the pwm_out high count at each frame_tick.
// Underrun count is predicted from boundaries seen minus samples loaded.
module tb_wave_pwm_dac;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready, pwm_out, frame_tick, underrun;
  logic [7:0] underrun_cnt;

  logic [7:0] s4_in;
  logic       s4_vld;
  logic       s4_rdy, pwm4, ft4, ur4;
  logic [7:0] urc4;

  wave_pwm_dac #(.WIDTH(8), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .pwm_out(pwm_out), .frame_tick(frame_tick),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  wave_pwm_dac #(.WIDTH(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst), .sample_in(s4_in), .sample_valid(s4_vld),
    .sample_ready(s4_rdy), .pwm_out(pwm4), .frame_tick(ft4),
    .underrun(ur4), .underrun_cnt(urc4)
  );

  typedef struct {
    int frame;
    int duty;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;
  int  passed = 0;
  int  total = 0;
  int  n_pushed = 0;
  int  ecount = 0;
  int  frames = 0;
  int  acc = 0;
  int  cyc = 0;
  int  exp_duty = 0;
  int  mon_pending = 0;
  int  mon_exp_ur = 0;

  function automatic int conv(input logic [7:0] v);
`ifdef WAVE_PWM_SIGNED_IN_EN
    logic [7:0] t;
    t = {~v[7], v[6:0]};
    return int'(t);
`else
    return int'(v);
`endif
  endfunction

  // Posedges since reset release; edge e with e%256==0 is a period boundary
  always @(posedge clk or negedge rst) begin
    if (!rst) ecount = 0;
    else ecount = ecount + 1;
  end

  // Period monitor: compares high count, period length and underrun state at each frame_tick
  always @(negedge clk) begin
    if (!rst) begin
      acc = 0; cyc = 0; frames = 0; exp_duty = 0; n_pushed = 0;
      sb_q.delete();
    end else begin
      cyc = cyc + 1;
      if (pwm_out === 1'b1) acc = acc + 1;
      if (frame_tick === 1'b1) begin
        frames = frames + 1;
        if (sb_q.size() > 0 && sb_q[0].frame == frames) begin
          mon_e = sb_q.pop_front();
          exp_duty = mon_e.duty;
        end
        total++;
        if (acc !== exp_duty) $display("FAIL period_high frame %0d: got %0d high cycles, expected %0d", frames, acc, exp_duty);
        else passed++;
        if (frames > 1) begin
          total++;
          if (cyc !== 256) $display("FAIL period_len frame %0d: got %0d cycles, expected 256", frames, cyc);
          else passed++;
        end
        mon_pending = 0;
        foreach (sb_q[i]) if (sb_q[i].frame > frames + 1) mon_pending++;
        mon_exp_ur = frames - (n_pushed - mon_pending);
        if (mon_exp_ur > 255) mon_exp_ur = 255;
        total++;
        if (underrun_cnt !== 8'(mon_exp_ur) || underrun !== (mon_exp_ur > 0))
          $display("FAIL underrun frame %0d: got cnt %0d flag %0b, expected cnt %0d flag %0b",
                   frames, underrun_cnt, underrun, mon_exp_ur, (mon_exp_ur > 0));
        else passed++;
        acc = 0;
        cyc = 0;
      end
    end
  end

  task automatic push(input logic [7:0] v);
    int n;
    n = 0;
    @(negedge clk);
    sample_in = v;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      $display("FAIL push_timeout value %0h: sample_ready stayed %0b, expected 1", v, sample_ready);
      sample_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      sb_q.push_back('{frame: ecount / 256 + 2, duty: conv(v)});
      n_pushed++;
    end
  endtask

  task automatic wait_ft();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      total++;
      $display("FAIL frame_tick_timeout: frame_tick %0b after %0d cycles, expected 1", frame_tick, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; sample_valid = 1'b0; sample_in = 8'h00; s4_vld = 1'b0; s4_in = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (pwm_out !== 1'b0 || frame_tick !== 1'b0 || underrun !== 1'b0 || underrun_cnt !== 8'd0)
      $display("FAIL reset_outputs: pwm %0b ft %0b ur %0b cnt %0d, expected 0 0 0 0", pwm_out, frame_tick, underrun, underrun_cnt);
    else passed++;
    total++;
    if (sample_ready !== 1'b1 || s4_rdy !== 1'b1)
      $display("FAIL reset_ready: got %0b/%0b, expected 1/1", sample_ready, s4_rdy);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_idle();
    wait_ft();
    total++;
    if (underrun !== 1'b1 || underrun_cnt !== 8'd1)
      $display("FAIL idle_underrun: flag %0b cnt %0d, expected 1 1", underrun, underrun_cnt);
    else passed++;
    total++;
    if (sample_ready !== 1'b1) $display("FAIL idle_ready: got %0b, expected 1", sample_ready);
    else passed++;
  endtask

  task automatic test_single();
    wait_ft();
    push(8'h40);
    wait_ft();
    total++;
    if (pwm_out !== 1'b0) $display("FAIL single_edge_before: pwm %0b, expected 0", pwm_out);
    else passed++;
    @(negedge clk);
    total++;
    if (pwm_out !== 1'b1 || frame_tick !== 1'b0)
      $display("FAIL single_edge_after: pwm %0b ft %0b, expected 1 0", pwm_out, frame_tick);
    else passed++;
    wait_ft();
  endtask

  task automatic test_sequence();
    wait_ft();
    push(8'hFF);
    total++;
    if (sample_ready !== 1'b0) $display("FAIL seq_full: ready %0b, expected 0", sample_ready);
    else passed++;
    wait_ft();
    push(8'h00);
    repeat (3) wait_ft();
  endtask

  task automatic test_hold();
    wait_ft();
    push(8'h20);
    @(negedge clk);
    total++;
    if (sample_ready !== 1'b0) $display("FAIL hold_ready: got %0b, expected 0", sample_ready);
    else passed++;
    push(8'h90);
    total++;
    if ((ecount % 256) !== 1) $display("FAIL hold_accept_edge: accepted at edge %0d of period, expected 1", ecount % 256);
    else passed++;
    repeat (3) wait_ft();
  endtask

  task automatic test_prescale();
    int n, hi;
    n = 0;
    @(negedge clk);
    while (ft4 !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
    total++;
    if (n >= 1100) $display("FAIL pre4_first_tick: ft4 %0b after %0d cycles, expected 1", ft4, n);
    else passed++;
    total++;
    if (s4_rdy !== 1'b1) $display("FAIL pre4_ready: got %0b, expected 1", s4_rdy);
    else passed++;
    s4_in = 8'h10;
    s4_vld = 1'b1;
    @(posedge clk);
    #1;
    s4_vld = 1'b0;
    n = 0;
    @(negedge clk); n++;
    while (ft4 !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
    total++;
    if (n !== 1024) $display("FAIL pre4_period: got %0d cycles, expected 1024", n);
    else passed++;
    n = 0; hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm4 === 1'b1) hi++;
    end while (ft4 !== 1'b1 && n < 1100);
    total++;
    if (n !== 1024 || hi !== 4 * conv(8'h10))
      $display("FAIL pre4_high: got %0d of %0d cycles, expected %0d of 1024", hi, n, 4 * conv(8'h10));
    else passed++;
  endtask

  task automatic test_starve();
    int n;
    n = 0;
    while (frames < 262 && n < 300) begin wait_ft(); n++; end
    total++;
    if (underrun_cnt !== 8'd255 || underrun !== 1'b1)
      $display("FAIL starve_sat: cnt %0d flag %0b, expected 255 1", underrun_cnt, underrun);
    else passed++;
  endtask

  task automatic test_async_reset();
    int n;
    wait_ft();
    push(8'hC0);
    wait_ft();
    repeat (10) @(negedge clk);
    total++;
    if (pwm_out !== 1'b1) $display("FAIL areset_pre: pwm %0b, expected 1", pwm_out);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (pwm_out !== 1'b0 || frame_tick !== 1'b0 || underrun !== 1'b0 || underrun_cnt !== 8'd0 || sample_ready !== 1'b1)
      $display("FAIL areset_clear: pwm %0b ft %0b ur %0b cnt %0d rdy %0b, expected 0 0 0 0 1",
               pwm_out, frame_tick, underrun, underrun_cnt, sample_ready);
    else passed++;
    total++;
    if (ur4 !== 1'b0 || urc4 !== 8'd0) $display("FAIL areset_pre4: ur %0b cnt %0d, expected 0 0", ur4, urc4);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 600);
    total++;
    if (n !== 256) $display("FAIL areset_first_period: got %0d cycles, expected 256", n);
    else passed++;
    push(8'h00);
    repeat (3) wait_ft();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_sequence();
    test_hold();
    test_prescale();
    test_starve();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
